// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if: VEDA memory port and fp_adder operand/result bundle.
// master = sequencer side, slave = memory/adder side.
interface fp_add_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_mode;
  logic              mem_write_enable;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic [31:0]       add_result;

  modport master (
    output mem_address, mem_mode, mem_write_enable, mem_data_in, add_a, add_b,
    input  mem_data_out, add_result
  );

  modport slave (
    input  mem_address, mem_mode, mem_write_enable, mem_data_in, add_a, add_b,
    output mem_data_out, add_result
  );
endinterface

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: walks {a, b, expected} entries stored in VEDA memory,
// feeds each a/b pair to the fp_adder and tallies sums that differ from the
// expected word.
// Optional feature macro: FP_SEQ_WRITEBACK_EN -- adds a WB state that writes
// every computed sum over its expected word (5 cycles per entry instead of 4).
//
// state | meaning
// IDLE  | waiting for start
// RD_A  | present ptr
// RD_B  | present ptr+1, capture a
// RD_E  | present ptr+2, capture b
// CHECK | compare adder sum with expected word
// WB    | write sum to ptr+2 (writeback build only)
// DONE  | one-cycle completion pulse
module fp_add_sequencer #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    count,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    first_err_idx,
  fp_add_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    RD_E  = 3'd3,
    CHECK = 3'd4,
`ifdef FP_SEQ_WRITEBACK_EN
    WB    = 3'd5,
`endif
    DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TWO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_THREE = ADDR_W'(3);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remain;
  logic [CNT_W-1:0]  idx;
  logic              last_entry;
  logic              mismatch;
  logic              entry_end;

  assign last_entry = (remain == CNT_ONE);
  assign mismatch   = (bus.add_result != bus.mem_data_out);
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign pass       = (err_count == '0);

  // The pointer steps once the last state of an entry has run.
`ifdef FP_SEQ_WRITEBACK_EN
  assign entry_end = (state == WB);
`else
  assign entry_end = (state == CHECK);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and VEDA control; idle/done park the bus at address 0 in read mode.
  always_comb begin
    state_nxt            = state;
    bus.mem_address      = '0;
    bus.mem_mode         = 1'b1;
    bus.mem_write_enable = 1'b0;
    bus.mem_data_in      = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? DONE : RD_A;
      end
      RD_A: begin
        bus.mem_address = ptr;
        state_nxt       = RD_B;
      end
      RD_B: begin
        bus.mem_address = ptr + ADDR_ONE;
        state_nxt       = RD_E;
      end
      RD_E: begin
        bus.mem_address = ptr + ADDR_TWO;
        state_nxt       = CHECK;
      end
      CHECK: begin
`ifdef FP_SEQ_WRITEBACK_EN
        state_nxt = WB;
`else
        state_nxt = last_entry ? DONE : RD_A;
`endif
      end
`ifdef FP_SEQ_WRITEBACK_EN
      WB: begin
        bus.mem_address      = ptr + ADDR_TWO;
        bus.mem_mode         = 1'b0;
        bus.mem_write_enable = 1'b1;
        bus.mem_data_in      = bus.add_result;
        state_nxt            = last_entry ? DONE : RD_A;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Run setup, operand capture, mismatch tally and entry advance (remain is a down-counter).
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      remain        <= '0;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
    end else begin
      if (state == IDLE && start) begin
        ptr           <= base_addr;
        remain        <= count;
        idx           <= '0;
        err_count     <= '0;
        first_err_idx <= '1;
      end
      if (state == RD_B) bus.add_a <= bus.mem_data_out;
      if (state == RD_E) bus.add_b <= bus.mem_data_out;
      if (state == CHECK && mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_ONE;
        if (err_count == '0) first_err_idx <= idx;
      end
      if (entry_end) begin
        ptr    <= ptr + ADDR_THREE;
        remain <= remain - CNT_ONE;
        idx    <= idx + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: drives fp_add_sequencer against a VEDA memory model and
// a behavioural fp adder; build with FP_SEQ_WRITEBACK_EN to exercise writeback.
module tb_fp_add_sequencer;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 32;
`ifdef FP_SEQ_WRITEBACK_EN
  localparam int LAT   = 5;
  localparam int WB_ON = 1;
`else
  localparam int LAT   = 4;
  localparam int WB_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_count, first_err_idx;

  fp_add_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  fp_add_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] img     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          load_req = 1'b0;

  int                lat;
  int                wr_seen;
  bit                timed_out;
  logic [ADDR_W-1:0] addr_log [$];
  int                exp_err;
  logic [CNT_W-1:0]  exp_first;

  // IEEE single <-> double conversion for normal numbers and zero.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [31:0] t;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    t = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) t = t + 32'd1;
    return t;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'b0, 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // VEDA memory: synchronous read one cycle after the address, write when mode=0 and we=1.
  always @(posedge clk) begin
    if (load_req) mem <= img;
    else begin
      if (bus.mem_write_enable && !bus.mem_mode) mem[bus.mem_address] <= bus.mem_data_in;
      if (bus.mem_mode) bus.mem_data_out <= mem[bus.mem_address];
    end
  end

  assign bus.add_result = fp_add(bus.add_a, bus.add_b);

  task automatic load_mem;
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  // Reference: entries processed in order over ref_mem, sums written back when enabled.
  task automatic model(input int b, input int c);
    logic [31:0] s;
    int p;
    exp_err = 0;
    exp_first = '1;
    for (int i = 0; i < c; i++) begin
      p = (b + 3 * i) % DEPTH;
      s = fp_add(ref_mem[p], ref_mem[(p + 1) % DEPTH]);
      if (s != ref_mem[(p + 2) % DEPTH]) begin
        if (exp_err == 0) exp_first = CNT_W'(i);
        if (exp_err < (1 << CNT_W) - 1) exp_err++;
      end
      if (WB_ON != 0) ref_mem[(p + 2) % DEPTH] = s;
    end
  endtask

  task automatic run_seq(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c, input bit glitch);
    addr_log.delete();
    wr_seen = 0; lat = 0; timed_out = 1'b0;
    @(negedge clk);
    base_addr = b; count = c; start = 1'b1;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (glitch && lat == 2) begin start = 1'b1; count = ~c; base_addr = ~b; end
      if (glitch && lat == 3) start = 1'b0;
      addr_log.push_back(bus.mem_address);
      if (bus.mem_write_enable) wr_seen++;
      if (done) break;
      if (lat > 400) begin timed_out = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL reset_pass: got %b want 1", pass); end
    vectors++; if (err_count !== '0) begin miscompares++; $display("FAIL reset_err: got %0d want 0", err_count); end
    vectors++; if (first_err_idx !== '1) begin miscompares++; $display("FAIL reset_first: got %0d want 15", first_err_idx); end
    vectors++; if (bus.add_a !== 32'd0 || bus.add_b !== 32'd0) begin miscompares++; $display("FAIL reset_operands: got %h/%h want 0/0", bus.add_a, bus.add_b); end
    vectors++; if (bus.mem_address !== '0 || bus.mem_mode !== 1'b1 || bus.mem_write_enable !== 1'b0 || bus.mem_data_in !== 32'd0) begin
      miscompares++; $display("FAIL reset_veda: got addr=%0d mode=%b we=%b din=%h want 0/1/0/0", bus.mem_address, bus.mem_mode, bus.mem_write_enable, bus.mem_data_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    for (int w = 0; w < DEPTH; w++) img[w] = 32'd0;
    img[0] = 32'h3F800000; img[1] = 32'h3F800000; img[2] = 32'h40000000;
    load_mem;
    run_seq(0, 1, 1'b0);
    vectors++; if (timed_out || lat != 1 + LAT) begin miscompares++; $display("FAIL single_latency: got %0d want %0d", lat, 1 + LAT); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL single_pass: got %b want 1", pass); end
    vectors++; if (err_count !== '0) begin miscompares++; $display("FAIL single_err: got %0d want 0", err_count); end
    vectors++; if (first_err_idx !== '1) begin miscompares++; $display("FAIL single_first: got %0d want 15", first_err_idx); end
  endtask

  task automatic test_mismatch;
    for (int w = 0; w < DEPTH; w++) img[w] = 32'd0;
    img[0] = 32'h42BA8000; img[1] = 32'h414D0000; img[2] = 32'h42D42000;
    img[3] = 32'h42BA8000; img[4] = 32'h414D0000; img[5] = 32'h42D40000;
    load_mem;
    run_seq(0, 2, 1'b0);
    vectors++; if (timed_out || lat != 1 + 2 * LAT) begin miscompares++; $display("FAIL mismatch_latency: got %0d want %0d", lat, 1 + 2 * LAT); end
    vectors++; if (err_count !== 4'd1) begin miscompares++; $display("FAIL mismatch_err: got %0d want 1", err_count); end
    vectors++; if (first_err_idx !== 4'd1) begin miscompares++; $display("FAIL mismatch_first: got %0d want 1", first_err_idx); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL mismatch_pass: got %b want 0", pass); end
  endtask

  task automatic test_zero_count;
    int nonzero;
    run_seq(7, 0, 1'b0);
    nonzero = 0;
    foreach (addr_log[i]) if (addr_log[i] !== '0) nonzero++;
    vectors++; if (timed_out || lat != 1) begin miscompares++; $display("FAIL zero_latency: got %0d want 1", lat); end
    vectors++; if (pass !== 1'b1 || err_count !== '0) begin miscompares++; $display("FAIL zero_result: got pass=%b err=%0d want 1/0", pass, err_count); end
    vectors++; if (nonzero != 0) begin miscompares++; $display("FAIL zero_addr: got %0d nonzero addresses want 0", nonzero); end
  endtask

  task automatic test_wrap;
    logic [ADDR_W-1:0] got0, got1, got2;
    run_seq(30, 1, 1'b0);
    got0 = addr_log.size() > 0 ? addr_log[0] : 'x;
    got1 = addr_log.size() > 1 ? addr_log[1] : 'x;
    got2 = addr_log.size() > 2 ? addr_log[2] : 'x;
    vectors++; if (got0 !== 5'd30 || got1 !== 5'd31 || got2 !== 5'd0) begin
      miscompares++; $display("FAIL wrap_addr: got %0d,%0d,%0d want 30,31,0", got0, got1, got2);
    end
    vectors++; if (timed_out || lat != 1 + LAT) begin miscompares++; $display("FAIL wrap_latency: got %0d want %0d", lat, 1 + LAT); end
  endtask

  task automatic test_writeback;
    for (int w = 0; w < DEPTH; w++) img[w] = 32'd0;
    img[0] = 32'h42BA8000; img[1] = 32'h414D0000; img[2] = 32'h42D40000;
    load_mem;
    run_seq(0, 1, 1'b0);
    @(negedge clk);
    vectors++; if (mem[2] !== ((WB_ON != 0) ? 32'h42D42000 : 32'h42D40000)) begin
      miscompares++; $display("FAIL writeback_mem2: got %h want %h", mem[2], (WB_ON != 0) ? 32'h42D42000 : 32'h42D40000);
    end
    vectors++; if (err_count !== 4'd1 || first_err_idx !== 4'd0) begin miscompares++; $display("FAIL writeback_err: got %0d/%0d want 1/0", err_count, first_err_idx); end
    vectors++; if (wr_seen != WB_ON) begin miscompares++; $display("FAIL writeback_writes: got %0d want %0d", wr_seen, WB_ON); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    for (int w = 0; w < DEPTH; w++) img[w] = 32'd0;
    img[0] = 32'h42BA8000; img[1] = 32'h414D0000; img[2] = 32'h42D40000;
    img[3] = 32'h3F800000; img[4] = 32'h3F800000; img[5] = 32'h40000000;
    load_mem;
    @(negedge clk);
    base_addr = 0; count = 2; start = 1'b1;
    cyc = 0;
    while (cyc < 3 + LAT) begin
      @(negedge clk); cyc++;
      if (cyc == 1) start = 1'b0;
    end
    vectors++; if (err_count !== 4'd1) begin miscompares++; $display("FAIL midreset_pre_err: got %0d want 1", err_count); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_state: got busy=%b done=%b want 0/0", busy, done); end
    vectors++; if (err_count !== '0 || first_err_idx !== '1) begin miscompares++; $display("FAIL midreset_err: got %0d/%0d want 0/15", err_count, first_err_idx); end
    vectors++; if (bus.mem_write_enable !== 1'b0 || bus.mem_address !== '0) begin miscompares++; $display("FAIL midreset_veda: got we=%b addr=%0d want 0/0", bus.mem_write_enable, bus.mem_address); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_start_while_busy;
    for (int w = 0; w < DEPTH; w++) img[w] = rnd_fp();
    load_mem;
    run_seq(3, 3, 1'b1);
    vectors++; if (timed_out || lat != 1 + 3 * LAT) begin miscompares++; $display("FAIL busy_start_latency: got %0d want %0d", lat, 1 + 3 * LAT); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_start_ignored: got busy=%b want 0", busy); end
  endtask

  task automatic test_random;
    int b, c, p, diff;
    for (int it = 0; it < 8; it++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = (it == 0) ? 15 : $urandom_range(1, 8);
      for (int w = 0; w < DEPTH; w++) img[w] = rnd_fp();
      if (it != 0)
        for (int i = 0; i < c; i++)
          if ($urandom_range(0, 1) == 1) begin
            p = (b + 3 * i) % DEPTH;
            img[(p + 2) % DEPTH] = fp_add(img[p], img[(p + 1) % DEPTH]);
          end
      ref_mem = img;
      model(b, c);
      load_mem;
      run_seq(ADDR_W'(b), CNT_W'(c), 1'b0);
      @(negedge clk);
      diff = 0;
      for (int w = 0; w < DEPTH; w++) if (mem[w] !== ref_mem[w]) diff++;
      vectors++; if (timed_out || lat != 1 + LAT * c) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, 1 + LAT * c); end
      vectors++; if (err_count !== CNT_W'(exp_err)) begin miscompares++; $display("FAIL rand%0d_err: got %0d want %0d", it, err_count, exp_err); end
      vectors++; if (first_err_idx !== exp_first) begin miscompares++; $display("FAIL rand%0d_first: got %0d want %0d", it, first_err_idx, exp_first); end
      vectors++; if (pass !== (exp_err == 0)) begin miscompares++; $display("FAIL rand%0d_pass: got %b want %b", it, pass, exp_err == 0); end
      vectors++; if (wr_seen != WB_ON * c) begin miscompares++; $display("FAIL rand%0d_writes: got %0d want %0d", it, wr_seen, WB_ON * c); end
      vectors++; if (diff != 0) begin miscompares++; $display("FAIL rand%0d_mem: got %0d differing words want 0", it, diff); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    test_reset;
    test_single;
    test_mismatch;
    test_zero_count;
    test_wrap;
    test_writeback;
    test_reset_mid;
    test_start_while_busy;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
